// File: rtl/ex_mem_stage_controller_if.sv
// Data-memory bus between the EX/MEM stage controller and the data memory.
//   mem_req        : access request, held until mem_ack
//   mem_write      : 1 = store, 0 = load (meaningful while mem_req=1)
//   mem_address    : byte address of the access
//   mem_write_data : store data
//   mem_ack        : memory completes the access this cycle
//   mem_read_data  : load data, valid when mem_ack=1
// master: the stage controller; slave: the memory.
interface ex_mem_stage_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_req,
    output mem_write,
    output mem_address,
    output mem_write_data,
    input  mem_ack,
    input  mem_read_data
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  mem_address,
    input  mem_write_data,
    output mem_ack,
    output mem_read_data
  );
endinterface

// File: rtl/ex_mem_stage_controller.sv
// EX/MEM pipeline stage of the MIPS32 core.
// Holds one instruction (register R), runs the data-memory request/ack handshake for loads and
// stores, stalls IF/ID/EX while an access is outstanding and hands completed instructions to
// MEM/WB one cycle after completion.
// Ports:
//   clock, reset_n       : pipeline clock, asynchronous active-low reset
//   in_*                 : instruction and ID/EX control bits from the EX stage
//   flush                : turn the instruction on in_* into a bubble at the next capture edge
//   stall_upstream       : combinational hold request towards IF/ID/EX
//   mem_bus              : data-memory handshake (master side)
//   wb_*                 : MEM/WB register contents
//   misaligned_fault     : one-cycle pulse after capturing a misaligned memory op
//   timeout_fault        : sticky, set when an access is abandoned for lack of mem_ack
module ex_mem_stage_controller #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic                      in_write_data_memory,
  input  logic                      in_read_data_memory,
  input  logic                      in_write_register,
  input  logic                      in_mem_to_register,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest_register,
  input  logic                      flush,
  output logic                      stall_upstream,
  ex_mem_stage_controller_if.master mem_bus,
  output logic                      wb_valid,
  output logic                      wb_write_register,
  output logic                      wb_mem_to_register,
  output logic [DATA_WIDTH-1:0]     wb_alu_result,
  output logic [DATA_WIDTH-1:0]     wb_load_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_dest_register,
  output logic                      misaligned_fault,
  output logic                      timeout_fault
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e                    state_q;
  logic [7:0]                wait_q;

  // Register R
  logic                      r_valid_q;
  logic                      r_write_mem_q;
  logic                      r_read_mem_q;
  logic                      r_write_register_q;
  logic                      r_mem_to_register_q;
  logic [DATA_WIDTH-1:0]     r_alu_result_q;
  logic [REG_ADDR_WIDTH-1:0] r_dest_register_q;

  logic                      mem_req_q;
  logic                      mem_write_q;
  logic [DATA_WIDTH-1:0]     mem_address_q;
  logic [DATA_WIDTH-1:0]     mem_write_data_q;

  logic                      wb_valid_q;
  logic                      wb_write_register_q;
  logic                      wb_mem_to_register_q;
  logic [DATA_WIDTH-1:0]     wb_alu_result_q;
  logic [DATA_WIDTH-1:0]     wb_load_data_q;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_register_q;
  logic                      misaligned_fault_q;
  logic                      timeout_fault_q;

  logic in_access;
  logic timeout_hit;
  logic complete;
  logic load_done;
  logic new_valid;
  logic new_mem;
  logic new_misaligned;

  always_comb begin
    in_access      = (state_q == StAccess);
    // An ack in the last allowed cycle wins over the timeout.
    timeout_hit    = in_access && !mem_bus.mem_ack && (wait_q == WaitLast);
    // Completion and capture coincide: R frees up exactly when its instruction completes.
    complete       = !in_access || mem_bus.mem_ack || timeout_hit;
    stall_upstream = !complete;
    load_done      = in_access && mem_bus.mem_ack && r_read_mem_q && !r_write_mem_q;
    new_valid      = in_valid && !flush;
    new_mem        = new_valid && (in_write_data_memory || in_read_data_memory);
    new_misaligned = new_mem && (in_alu_result[1:0] != 2'b00);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= StIdle;
      wait_q               <= '0;
      r_valid_q            <= 1'b0;
      r_write_mem_q        <= 1'b0;
      r_read_mem_q         <= 1'b0;
      r_write_register_q   <= 1'b0;
      r_mem_to_register_q  <= 1'b0;
      r_alu_result_q       <= '0;
      r_dest_register_q    <= '0;
      mem_req_q            <= 1'b0;
      mem_write_q          <= 1'b0;
      mem_address_q        <= '0;
      mem_write_data_q     <= '0;
      wb_valid_q           <= 1'b0;
      wb_write_register_q  <= 1'b0;
      wb_mem_to_register_q <= 1'b0;
      wb_alu_result_q      <= '0;
      wb_load_data_q       <= '0;
      wb_dest_register_q   <= '0;
      misaligned_fault_q   <= 1'b0;
      timeout_fault_q      <= 1'b0;
    end else begin
      misaligned_fault_q <= 1'b0;
      if (timeout_hit) begin
        timeout_fault_q <= 1'b1;
      end
      if (complete) begin
        // Retire R into MEM/WB; an abandoned access must not write the register file.
        wb_valid_q           <= r_valid_q;
        wb_write_register_q  <= r_write_register_q && !timeout_hit;
        wb_mem_to_register_q <= r_mem_to_register_q;
        wb_alu_result_q      <= r_alu_result_q;
        wb_dest_register_q   <= r_dest_register_q;
        wb_load_data_q       <= load_done ? mem_bus.mem_read_data : '0;
        // Capture the next instruction; a misaligned memory op becomes a bubble.
        r_valid_q            <= new_valid && !new_misaligned;
        r_write_mem_q        <= in_write_data_memory;
        r_read_mem_q         <= in_read_data_memory;
        r_write_register_q   <= in_write_register;
        r_mem_to_register_q  <= in_mem_to_register;
        r_alu_result_q       <= in_alu_result;
        r_dest_register_q    <= in_dest_register;
        misaligned_fault_q   <= new_misaligned;
        wait_q               <= '0;
        if (new_mem && !new_misaligned) begin
          state_q          <= StAccess;
          mem_req_q        <= 1'b1;
          mem_write_q      <= in_write_data_memory;
          mem_address_q    <= in_alu_result;
          mem_write_data_q <= in_store_data;
        end else begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      end else begin
        wb_valid_q <= 1'b0;
        wait_q     <= wait_q + 8'd1;
      end
    end
  end

  assign mem_bus.mem_req        = mem_req_q;
  assign mem_bus.mem_write      = mem_write_q;
  assign mem_bus.mem_address    = mem_address_q;
  assign mem_bus.mem_write_data = mem_write_data_q;

  assign wb_valid           = wb_valid_q;
  assign wb_write_register  = wb_write_register_q;
  assign wb_mem_to_register = wb_mem_to_register_q;
  assign wb_alu_result      = wb_alu_result_q;
  assign wb_load_data       = wb_load_data_q;
  assign wb_dest_register   = wb_dest_register_q;
  assign misaligned_fault   = misaligned_fault_q;
  assign timeout_fault      = timeout_fault_q;

endmodule

// File: tb/tb_ex_mem_stage_controller.sv
module tb_ex_mem_stage_controller;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned TO = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_write_data_memory = 1'b0;
  logic          in_read_data_memory = 1'b0;
  logic          in_write_register = 1'b0;
  logic          in_mem_to_register = 1'b0;
  logic [DW-1:0] in_alu_result = '0;
  logic [DW-1:0] in_store_data = '0;
  logic [RW-1:0] in_dest_register = '0;
  logic          flush = 1'b0;
  logic          stall_upstream;
  logic          wb_valid;
  logic          wb_write_register;
  logic          wb_mem_to_register;
  logic [DW-1:0] wb_alu_result;
  logic [DW-1:0] wb_load_data;
  logic [RW-1:0] wb_dest_register;
  logic          misaligned_fault;
  logic          timeout_fault;

  ex_mem_stage_controller_if #(.DATA_WIDTH(DW)) mem_bus ();

  ex_mem_stage_controller #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(RW),
    .MEM_TIMEOUT   (TO)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .in_write_data_memory(in_write_data_memory),
    .in_read_data_memory (in_read_data_memory),
    .in_write_register   (in_write_register),
    .in_mem_to_register  (in_mem_to_register),
    .in_alu_result       (in_alu_result),
    .in_store_data       (in_store_data),
    .in_dest_register    (in_dest_register),
    .flush               (flush),
    .stall_upstream      (stall_upstream),
    .mem_bus             (mem_bus),
    .wb_valid            (wb_valid),
    .wb_write_register   (wb_write_register),
    .wb_mem_to_register  (wb_mem_to_register),
    .wb_alu_result       (wb_alu_result),
    .wb_load_data        (wb_load_data),
    .wb_dest_register    (wb_dest_register),
    .misaligned_fault    (misaligned_fault),
    .timeout_fault       (timeout_fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state: what MEM/WB must show after the previous instruction retires.
  logic          exp_wb_valid = 1'b0;
  logic          exp_wb_wr = 1'b0;
  logic          exp_wb_m2r = 1'b0;
  logic [DW-1:0] exp_wb_alu = '0;
  logic [DW-1:0] exp_wb_load = '0;
  logic [RW-1:0] exp_wb_dest = '0;
  logic          exp_timeout_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one instruction and follow it until it completes. d = number of ACCESS cycles
  // without ack before the ack cycle. Returns inside the completion cycle (after negedge).
  task automatic issue(input logic v, input logic w, input logic r, input logic wr,
                       input logic m2r, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input logic [RW-1:0] dest, input logic fl, input int d,
                       input logic flush_in_stall);
    logic          eff;
    logic          misal;
    logic          access;
    logic          tmo;
    int            cycles;
    logic [DW-1:0] rdata;
    eff    = v && !fl;
    misal  = eff && (w || r) && (alu % 4 != 0);
    access = eff && (w || r) && !misal;
    tmo    = access && (d >= int'(TO));
    cycles = !access ? 1 : (tmo ? int'(TO) : d + 1);
    rdata  = $urandom;
    in_valid             = v;
    in_write_data_memory = w;
    in_read_data_memory  = r;
    in_write_register    = wr;
    in_mem_to_register   = m2r;
    in_alu_result        = alu;
    in_store_data        = sd;
    in_dest_register     = dest;
    flush                = fl;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (c == 0) begin
        chk("wb_valid", wb_valid, exp_wb_valid);
        if (exp_wb_valid) begin
          chk("wb_write_register", wb_write_register, exp_wb_wr);
          chk("wb_mem_to_register", wb_mem_to_register, exp_wb_m2r);
          chk("wb_alu_result", wb_alu_result, exp_wb_alu);
          chk("wb_dest_register", wb_dest_register, exp_wb_dest);
          chk("wb_load_data", wb_load_data, exp_wb_load);
        end
        chk("misaligned_fault", misaligned_fault, misal);
        chk("timeout_fault", timeout_fault, exp_timeout_seen);
      end else begin
        chk("wb_valid_while_stalled", wb_valid, 1'b0);
        chk("misaligned_fault_later", misaligned_fault, 1'b0);
      end
      chk("mem_req", mem_bus.mem_req, access);
      if (access) begin
        chk("mem_write", mem_bus.mem_write, w);
        chk("mem_address", mem_bus.mem_address, alu);
        if (w) chk("mem_write_data", mem_bus.mem_write_data, sd);
      end
      // Outside an access the ack line is toggled at random: it must be ignored.
      mem_bus.mem_ack       = access ? (c == d) : 1'($urandom_range(0, 1));
      mem_bus.mem_read_data = (access && c == d) ? rdata : $urandom;
      if (c < cycles - 1) begin
        in_alu_result = $urandom;
        in_valid      = 1'($urandom_range(0, 1));
        flush         = flush_in_stall;
      end
      #1;
      chk("stall_upstream", stall_upstream, c < cycles - 1);
    end
    exp_wb_valid = eff && !misal;
    exp_wb_wr    = wr && !tmo;
    exp_wb_m2r   = m2r;
    exp_wb_alu   = alu;
    exp_wb_dest  = dest;
    exp_wb_load  = (access && r && !w && !tmo) ? rdata : '0;
    if (tmo) exp_timeout_seen = 1'b1;
  endtask

  initial begin
    logic          rv;
    logic          rw;
    logic          rr;
    logic          rfl;
    logic [DW-1:0] ralu;
    int            rd;
    int            op;

    mem_bus.mem_ack       = 1'b0;
    mem_bus.mem_read_data = '0;

    // Reset state
    #12;
    chk("reset_mem_req", mem_bus.mem_req, 1'b0);
    chk("reset_stall", stall_upstream, 1'b0);
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_timeout_fault", timeout_fault, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // ALU op
    issue(1, 0, 0, 1, 0, 32'h0000_00A5, 32'h0, 5'd8, 0, 0, 0);
    // Store acked on the third ACCESS cycle: two stall cycles
    issue(1, 1, 0, 0, 0, 32'h0000_1004, 32'hDEAD_BEEF, 5'd0, 0, 2, 0);
    // Back-to-back loads, first acked immediately
    issue(1, 0, 1, 1, 1, 32'h0000_0040, 32'h0, 5'd9, 0, 0, 0);
    issue(1, 0, 1, 1, 1, 32'h0000_0044, 32'h0, 5'd10, 0, 1, 0);
    // Misaligned store becomes a bubble, next op proceeds
    issue(1, 1, 0, 0, 0, 32'h0000_1002, 32'h1111_2222, 5'd0, 0, 0, 0);
    issue(1, 0, 0, 1, 0, 32'h0000_0077, 32'h0, 5'd3, 0, 0, 0);
    // Load that is never acked
    issue(1, 0, 1, 1, 1, 32'h0000_0200, 32'h0, 5'd12, 0, 1000, 0);
    issue(1, 0, 0, 1, 0, 32'h0000_0123, 32'h0, 5'd4, 0, 0, 0);
    // Both control bits set is a store
    issue(1, 1, 1, 0, 0, 32'h0000_0300, 32'hCAFE_F00D, 5'd0, 0, 1, 0);
    // flush while stalled is ignored, flush on a capture edge makes a bubble
    issue(1, 1, 0, 0, 0, 32'h0000_0400, 32'h5555_AAAA, 5'd0, 0, 3, 1);
    issue(1, 0, 0, 1, 0, 32'h0000_0099, 32'h0, 5'd6, 1, 0, 0);
    issue(1, 0, 0, 1, 0, 32'h0000_0098, 32'h0, 5'd7, 0, 0, 0);

    // Reset in the middle of an access
    in_valid             = 1'b1;
    in_write_data_memory = 1'b0;
    in_read_data_memory  = 1'b1;
    in_write_register    = 1'b1;
    in_alu_result        = 32'h0000_0800;
    flush                = 1'b0;
    @(negedge clock);
    mem_bus.mem_ack = 1'b0;
    #1;
    chk("pre_reset_mem_req", mem_bus.mem_req, 1'b1);
    chk("pre_reset_stall", stall_upstream, 1'b1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_mem_req", mem_bus.mem_req, 1'b0);
    chk("async_reset_stall", stall_upstream, 1'b0);
    chk("async_reset_timeout_fault", timeout_fault, 1'b0);
    chk("async_reset_wb_alu_result", wb_alu_result, 32'h0);
    chk("async_reset_wb_valid", wb_valid, 1'b0);
    @(negedge clock);
    reset_n          = 1'b1;
    exp_wb_valid     = 1'b0;
    exp_timeout_seen = 1'b0;
    issue(1, 0, 0, 1, 0, 32'h0000_0011, 32'h0, 5'd1, 0, 0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      op   = int'($urandom_range(0, 3));
      rv   = ($urandom_range(0, 9) != 0);
      rfl  = ($urandom_range(0, 9) == 0);
      rw   = (op == 2) || (op == 3);
      rr   = (op == 1) || (op == 3);
      ralu = $urandom;
      if ($urandom_range(0, 3) != 0) ralu = ralu & 32'hFFFF_FFFC;
      rd   = ($urandom_range(0, 19) == 0) ? 40 : int'($urandom_range(0, 4));
      issue(rv, rw, rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ralu, $urandom,
            5'($urandom_range(0, 31)), rfl, rd, 1'($urandom_range(0, 1)));
    end
    // Drain the last instruction into MEM/WB
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
